lcd_timing_gen: RTL and testbench
=================================

// Module: lcd_timing_gen
// PURPOSE
//  Parametrised raster timing generator for the LTM LCD panel and later panels.
//  Produces HD/VD sync, DEN and pixel coordinates from fully parametrised porch/sync/active timing.
//  Adds configurable sync polarity, clock enable, active-area coordinates and frame/line strobes.
//  Sits between the pixel-clock source and the pixel generator / frame-buffer read logic.
// PARAMETERS
//  H_SYNC   1    HD pulse width, pixel clocks
//  H_BP     215  horizontal back porch, pixel clocks
//  H_ACT    800  visible pixels per line
//  H_FP     40   horizontal front porch, pixel clocks
//  V_SYNC   1    VD pulse width, lines
//  V_BP     34   vertical back porch, lines
//  V_ACT    480  visible lines
//  V_FP     10   vertical front porch, lines
//  HS_POL   0    HD active level (0 = active-low)
//  VS_POL   0    VD active level (0 = active-low)
//  Derived localparams: H_TOTAL = sum of H_* (1056); V_TOTAL = sum of V_* (525).
//  HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL); XW = $clog2(H_ACT); YW = $clog2(V_ACT).
// PORTS
//  CLK          in   1   pixel clock
//  RST_n        in   1   asynchronous active-low reset
//  EN           in   1   clock enable; low freezes all state
//  HD           out  1   horizontal sync, level per HS_POL
//  VD           out  1   vertical sync, level per VS_POL
//  DEN          out  1   data enable, high inside the active area
//  columna      out  HW  raw horizontal count, 0..H_TOTAL-1
//  fila         out  VW  raw vertical count, 0..V_TOTAL-1
//  x            out  XW  active-area column, 0..H_ACT-1; 0 when DEN = 0
//  y            out  YW  active-area row, 0..V_ACT-1; 0 when DEN = 0
//  line_start   out  1   1-cycle pulse on the first active pixel of each active line
//  frame_start  out  1   1-cycle pulse when columna = 0 and fila = 0
// BEHAVIOUR
//  - Reset is asynchronous. It forces:
//    - columna, fila, x, y = 0
//    - DEN, line_start, frame_start = 0
//    - HD = ~HS_POL, VD = ~VS_POL (inactive)
//  - Every output is a register. No combinational path from inputs to outputs.
//  - On a CLK edge with EN = 1:
//    - columna advances and wraps H_TOTAL-1 -> 0.
//    - fila advances only when columna wraps, and wraps V_TOTAL-1 -> 0.
//    - All decoded outputs are computed from the NEW (next) count values.
//    - Result: HD/VD/DEN/x/y/strobes are cycle-aligned with the columna/fila they describe.
//  - Decode, with h = columna and v = fila:
//    - HD active when h < H_SYNC.
//    - VD active when v < V_SYNC.
//    - DEN = 1 when H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACT and V_SYNC+V_BP <= v < V_SYNC+V_BP+V_ACT.
//    - x = h-(H_SYNC+H_BP) and y = v-(V_SYNC+V_BP) when DEN = 1; otherwise x = y = 0.
//    - x/y are truncated to XW/YW bits; no overflow is possible.
//    - line_start = DEN & (h == H_SYNC+H_BP).
//    - frame_start = (h == 0) & (v == 0).
//  - EN = 0: counters and all outputs hold their values. Strobes hold too, so gate them with EN downstream.
//  - Boundaries:
//    - First enabled edge after reset gives columna = 1. Count 0 of the first frame therefore shows inactive sync.
//    - frame_start first fires after one full frame.
//    - Simultaneous H and V wrap gives columna = 0, fila = 0, frame_start = 1 on the same edge.
//  - Reset asserted mid-frame returns to reset values immediately. Restart is identical to power-up.
// STRUCTURE
//  - Shared package lcd_pkg holds:
//    - the LTM panel timing constants (defaults above);
//    - a polarity encoding constant.
//    Future panel variants add constant sets there.
//  - One sub-module, lcd_axis_counter (params MODULO, W). It is instantiated twice:
//    - ports: CLK, RST_n, EN, INC, count, next_count, wrap;
//    - wrap is combinational: INC & (count == MODULO-1).
//  - Top level holds the decode logic and the output registers.
// TESTING (bench params H 2/3/8/3 -> H_TOTAL 16, V 1/2/4/1 -> V_TOTAL 8, pols 0)
//  1. Release reset, EN = 1, run 3 frames -> columna period 16, fila period 128 clocks. frame_start every 128 clocks.
//  2. Line at fila = 3 -> DEN high for exactly columna 5..12. x = 0..7 there. line_start only at columna 5. HD low only at columna 0..1.
//  3. Full frame -> DEN lines are fila 3..6, y = 0..3. VD low only for fila 0. DEN count = 32 per frame.
//  4. EN low 10 cycles at columna 7 -> all outputs frozen; resume from columna 8 with no skipped count.
//  5. Assert RST_n mid-line at columna 9, fila 4 -> outputs go to reset values asynchronously, before the next edge. After release, sequence matches test 1.
//  6. Rerun test 2 with HS_POL = 1, VS_POL = 1 -> HD/VD inverted. DEN, x, y unchanged. Also check the default 1056/525 timing with H_SYNC + H_BP = 216 -> first DEN at columna 216, fila 35.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared raster timing constants and sync polarity encoding for LCD panels.
package lcd_pkg;

    // Sync polarity: the level a sync output takes while its pulse is active.
    typedef enum logic {
        POL_ACTIVE_LOW  = 1'b0,
        POL_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // LTM panel timing (pixel clocks horizontally, lines vertically).
    localparam int LTM_H_SYNC  = 1;
    localparam int LTM_H_BP    = 215;
    localparam int LTM_H_ACT   = 800;
    localparam int LTM_H_FP    = 40;
    localparam int LTM_V_SYNC  = 1;
    localparam int LTM_V_BP    = 34;
    localparam int LTM_V_ACT   = 480;
    localparam int LTM_V_FP    = 10;
    localparam sync_pol_e LTM_HS_POL = POL_ACTIVE_LOW;
    localparam sync_pol_e LTM_VS_POL = POL_ACTIVE_LOW;

    localparam int LTM_H_TOTAL = LTM_H_SYNC + LTM_H_BP + LTM_H_ACT + LTM_H_FP;
    localparam int LTM_V_TOTAL = LTM_V_SYNC + LTM_V_BP + LTM_V_ACT + LTM_V_FP;

    // Electrical level of a sync output given whether the pulse is active.
    function automatic logic sync_level(input logic active, input sync_pol_e pol);
        return active ? logic'(pol) : ~logic'(pol);
    endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Raster timing bundle: driven by the timing generator, consumed by pixel logic.
interface lcd_timing_gen_if
    import lcd_pkg::*;
#(
    parameter int HW = $clog2(LTM_H_TOTAL),
    parameter int VW = $clog2(LTM_V_TOTAL),
    parameter int XW = $clog2(LTM_H_ACT),
    parameter int YW = $clog2(LTM_V_ACT)
);
    // No handshake: every signal is a registered level that is valid on each
    // pixel clock edge where the generator's clock enable was high; the
    // consumer never stalls the generator.
    logic          HD;
    logic          VD;
    logic          DEN;
    logic [HW-1:0] columna;
    logic [VW-1:0] fila;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output HD, VD, DEN, columna, fila, x, y, line_start, frame_start
    );

    modport slave (
        input HD, VD, DEN, columna, fila, x, y, line_start, frame_start
    );

endinterface

// File: rtl/lcd_axis_counter.sv
// Modulo counter for one raster axis; exposes its next value so the decode
// logic can register outputs that line up with the new count.
module lcd_axis_counter #(
    parameter int MODULO = 16,
    parameter int W      = $clog2(MODULO)
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic         EN,
    input  logic         INC,
    output logic [W-1:0] count,
    output logic [W-1:0] next_count,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(MODULO - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step on INC, wrapping from MODULO-1 back to zero.
    always_comb begin
        wrap    = INC & (count_q == LAST);
        count_d = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (INC) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register, frozen while the clock enable is low.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            count_q <= '0;
        end else if (EN) begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign next_count = count_d;

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator: horizontal/vertical counters plus registered
// sync, data-enable, active-area coordinates and line/frame strobes.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int        H_SYNC = LTM_H_SYNC,
    parameter int        H_BP   = LTM_H_BP,
    parameter int        H_ACT  = LTM_H_ACT,
    parameter int        H_FP   = LTM_H_FP,
    parameter int        V_SYNC = LTM_V_SYNC,
    parameter int        V_BP   = LTM_V_BP,
    parameter int        V_ACT  = LTM_V_ACT,
    parameter int        V_FP   = LTM_V_FP,
    parameter sync_pol_e HS_POL = LTM_HS_POL,
    parameter sync_pol_e VS_POL = LTM_VS_POL
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             EN,
    lcd_timing_gen_if.master tmg
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_ACT);
    localparam int YW      = $clog2(V_ACT);

    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int H_ACT_END   = H_ACT_START + H_ACT;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int V_ACT_END   = V_ACT_START + V_ACT;

    logic [HW-1:0] h_count, h_next;
    logic [VW-1:0] v_count, v_next;
    logic          h_wrap, v_wrap;

    logic [31:0]   h_ext, v_ext;
    logic          h_in_act, v_in_act;

    logic          hd_d, vd_d, den_d, line_start_d, frame_start_d;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;
    logic          hd_q, vd_q, den_q, line_start_q, frame_start_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    // Pixel counter steps every enabled clock; line counter steps on its wrap.
    lcd_axis_counter #(.MODULO(H_TOTAL), .W(HW)) u_h_counter (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .EN         (EN),
        .INC        (1'b1),
        .count      (h_count),
        .next_count (h_next),
        .wrap       (h_wrap)
    );

    lcd_axis_counter #(.MODULO(V_TOTAL), .W(VW)) u_v_counter (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .EN         (EN),
        .INC        (h_wrap),
        .count      (v_count),
        .next_count (v_next),
        .wrap       (v_wrap)
    );

    // Decode from the next counts so the registered outputs describe the
    // same pixel as the counter registers after the edge.
    always_comb begin
        h_ext    = 32'(h_next);
        v_ext    = 32'(v_next);
        h_in_act = (h_ext >= H_ACT_START) && (h_ext < H_ACT_END);
        v_in_act = (v_ext >= V_ACT_START) && (v_ext < V_ACT_END);

        hd_d  = sync_level(h_ext < H_SYNC, HS_POL);
        vd_d  = sync_level(v_ext < V_SYNC, VS_POL);
        den_d = h_in_act & v_in_act;
        x_d   = den_d ? XW'(h_ext - 32'(H_ACT_START)) : '0;
        y_d   = den_d ? YW'(v_ext - 32'(V_ACT_START)) : '0;

        line_start_d  = den_d & (h_ext == H_ACT_START);
        // Next position is (0,0) exactly when both axes wrap on this edge.
        frame_start_d = h_wrap & v_wrap;
    end

    // Output registers: inactive sync on reset, hold everything when EN is low.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            hd_q          <= sync_level(1'b0, HS_POL);
            vd_q          <= sync_level(1'b0, VS_POL);
            den_q         <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (EN) begin
            hd_q          <= hd_d;
            vd_q          <= vd_d;
            den_q         <= den_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign tmg.HD          = hd_q;
    assign tmg.VD          = vd_q;
    assign tmg.DEN         = den_q;
    assign tmg.columna     = h_count;
    assign tmg.fila        = v_count;
    assign tmg.x           = x_q;
    assign tmg.y           = y_q;
    assign tmg.line_start  = line_start_q;
    assign tmg.frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: small 16x8 raster in both polarities plus the
// default LTM timing, checked against an arithmetic raster model.
module tb_lcd_timing_gen;
    import lcd_pkg::*;

    typedef struct packed {
        logic [15:0] col;
        logic [15:0] fil;
        logic [15:0] x;
        logic [15:0] y;
        logic        hd;
        logic        vd;
        logic        den;
        logic        ls;
        logic        fs;
    } exp_t;

    logic clk;
    logic rst_n;
    logic en;
    int   checks;
    int   failures;
    int   n_edges;

    lcd_timing_gen_if #(.HW(4), .VW(3), .XW(3), .YW(2)) bus_b ();
    lcd_timing_gen_if #(.HW(4), .VW(3), .XW(3), .YW(2)) bus_p ();
    lcd_timing_gen_if #(.HW(11), .VW(10), .XW(10), .YW(9)) bus_d ();

    lcd_timing_gen #(
        .H_SYNC(2), .H_BP(3), .H_ACT(8), .H_FP(3),
        .V_SYNC(1), .V_BP(2), .V_ACT(4), .V_FP(1),
        .HS_POL(POL_ACTIVE_LOW), .VS_POL(POL_ACTIVE_LOW)
    ) dut_b (.CLK(clk), .RST_n(rst_n), .EN(en), .tmg(bus_b));

    lcd_timing_gen #(
        .H_SYNC(2), .H_BP(3), .H_ACT(8), .H_FP(3),
        .V_SYNC(1), .V_BP(2), .V_ACT(4), .V_FP(1),
        .HS_POL(POL_ACTIVE_HIGH), .VS_POL(POL_ACTIVE_HIGH)
    ) dut_p (.CLK(clk), .RST_n(rst_n), .EN(en), .tmg(bus_p));

    lcd_timing_gen dut_d (.CLK(clk), .RST_n(rst_n), .EN(en), .tmg(bus_d));

    // Clock and enabled-edge counter (the model's notion of time since reset).
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_edges <= 0;
        else if (en) n_edges <= n_edges + 1;
    end

    // Raster model: position after n enabled edges is n mod line/frame length.
    function automatic exp_t model(int n, int hs, int hbp, int hact, int hfp,
                                   int vs, int vbp, int vact, int vfp, bit hpol, bit vpol);
        exp_t e;
        int ht, vt, h, v;
        e = '0;
        ht = hs + hbp + hact + hfp;
        vt = vs + vbp + vact + vfp;
        if (n == 0) begin
            e.hd = ~hpol;
            e.vd = ~vpol;
            return e;
        end
        h = n % ht;
        v = (n / ht) % vt;
        e.col = 16'(h);
        e.fil = 16'(v);
        e.hd  = (h < hs) ? hpol : ~hpol;
        e.vd  = (v < vs) ? vpol : ~vpol;
        e.den = (h >= hs + hbp) && (h < hs + hbp + hact) && (v >= vs + vbp) && (v < vs + vbp + vact);
        if (e.den) begin
            e.x = 16'(h - hs - hbp);
            e.y = 16'(v - vs - vbp);
        end
        e.ls = e.den && (h == hs + hbp);
        e.fs = (h == 0) && (v == 0);
        return e;
    endfunction

    function automatic exp_t model_b(int n);
        return model(n, 2, 3, 8, 3, 1, 2, 4, 1, 1'b0, 1'b0);
    endfunction
    function automatic exp_t model_p(int n);
        return model(n, 2, 3, 8, 3, 1, 2, 4, 1, 1'b1, 1'b1);
    endfunction
    function automatic exp_t model_d(int n);
        return model(n, 1, 215, 800, 40, 1, 34, 480, 10, 1'b0, 1'b0);
    endfunction

    function automatic exp_t obs_b();
        exp_t o;
        o = '0;
        o.col = 16'(bus_b.columna); o.fil = 16'(bus_b.fila);
        o.x = 16'(bus_b.x); o.y = 16'(bus_b.y);
        o.hd = bus_b.HD; o.vd = bus_b.VD; o.den = bus_b.DEN;
        o.ls = bus_b.line_start; o.fs = bus_b.frame_start;
        return o;
    endfunction
    function automatic exp_t obs_p();
        exp_t o;
        o = '0;
        o.col = 16'(bus_p.columna); o.fil = 16'(bus_p.fila);
        o.x = 16'(bus_p.x); o.y = 16'(bus_p.y);
        o.hd = bus_p.HD; o.vd = bus_p.VD; o.den = bus_p.DEN;
        o.ls = bus_p.line_start; o.fs = bus_p.frame_start;
        return o;
    endfunction
    function automatic exp_t obs_d();
        exp_t o;
        o = '0;
        o.col = 16'(bus_d.columna); o.fil = 16'(bus_d.fila);
        o.x = 16'(bus_d.x); o.y = 16'(bus_d.y);
        o.hd = bus_d.HD; o.vd = bus_d.VD; o.den = bus_d.DEN;
        o.ls = bus_d.line_start; o.fs = bus_d.frame_start;
        return o;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_b() !== model_b(0)) begin
            failures++;
            $display("FAIL reset_b got=%h exp=%h", obs_b(), model_b(0));
        end
        checks++;
        if (obs_p() !== model_p(0)) begin
            failures++;
            $display("FAIL reset_p got=%h exp=%h", obs_p(), model_p(0));
        end
        checks++;
        if (obs_d() !== model_d(0)) begin
            failures++;
            $display("FAIL reset_d got=%h exp=%h", obs_d(), model_d(0));
        end
        checks++;
        if (bus_b.HD !== 1'b1 || bus_b.VD !== 1'b1 || bus_p.HD !== 1'b0 || bus_p.VD !== 1'b0) begin
            failures++;
            $display("FAIL reset_sync_levels got=%b%b%b%b exp=1100", bus_b.HD, bus_b.VD, bus_p.HD, bus_p.VD);
        end
    endtask

    // Three frames from reset release with EN held high.
    task automatic test_frames();
        int fs_at[$];
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 1; k <= 384; k++) begin
            @(negedge clk);
            if (bus_b.frame_start === 1'b1) fs_at.push_back(n_edges);
            checks++;
            if (obs_b() !== model_b(n_edges)) begin
                failures++;
                $display("FAIL frames_b n=%0d got=%h exp=%h", n_edges, obs_b(), model_b(n_edges));
            end
            checks++;
            if (obs_p() !== model_p(n_edges)) begin
                failures++;
                $display("FAIL frames_p n=%0d got=%h exp=%h", n_edges, obs_p(), model_p(n_edges));
            end
            if (k == 1) begin
                checks++;
                if (bus_b.columna !== 4'd1) begin
                    failures++;
                    $display("FAIL first_edge_col got=%0d exp=1", bus_b.columna);
                end
            end
        end
        checks++;
        if (fs_at.size() != 3) begin
            failures++;
            $display("FAIL frame_start_count got=%0d exp=3", fs_at.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (fs_at[i] != 128 * (i + 1)) begin
                    failures++;
                    $display("FAIL frame_start_pos got=%0d exp=%0d", fs_at[i], 128 * (i + 1));
                end
            end
        end
    endtask

    // One active line (fila 3) column by column, both polarities.
    task automatic test_line();
        bit found;
        bit den_e, ls_e, hd_e;
        int x_e;
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bus_b.columna === 4'd0 && bus_b.fila === 3'd3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL line_align got=timeout exp=columna0_fila3");
        end
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            den_e = (c >= 5) && (c <= 12);
            x_e   = den_e ? c - 5 : 0;
            ls_e  = (c == 5);
            hd_e  = (c >= 2);
            checks++;
            if (bus_b.columna !== 4'(c) || bus_b.DEN !== den_e || bus_b.x !== 3'(x_e) ||
                bus_b.y !== 2'd0 || bus_b.line_start !== ls_e || bus_b.HD !== hd_e) begin
                failures++;
                $display("FAIL line_b col=%0d got=den%b x%0d ls%b hd%b exp=den%b x%0d ls%b hd%b",
                         c, bus_b.DEN, bus_b.x, bus_b.line_start, bus_b.HD, den_e, x_e, ls_e, hd_e);
            end
            checks++;
            if (bus_p.DEN !== den_e || bus_p.x !== 3'(x_e) || bus_p.y !== 2'd0 ||
                bus_p.line_start !== ls_e || bus_p.HD !== ~hd_e || bus_p.VD !== 1'b0) begin
                failures++;
                $display("FAIL line_p col=%0d got=den%b x%0d hd%b vd%b exp=den%b x%0d hd%b vd0",
                         c, bus_p.DEN, bus_p.x, bus_p.HD, bus_p.VD, den_e, x_e, ~hd_e);
            end
        end
    endtask

    // One whole frame: active rows, y values, VD window and DEN total.
    task automatic test_frame();
        bit found;
        bit den_e, vd_e;
        int c, r, y_e, den_cnt;
        en = 1'b1;
        found = 1'b0;
        den_cnt = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus_b.columna === 4'd0 && bus_b.fila === 3'd0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL frame_align got=timeout exp=columna0_fila0");
        end
        for (int i = 0; i < 128; i++) begin
            if (i > 0) @(negedge clk);
            c = i % 16;
            r = i / 16;
            den_e = (r >= 3) && (r <= 6) && (c >= 5) && (c <= 12);
            y_e   = den_e ? r - 3 : 0;
            vd_e  = (r != 0);
            if (bus_b.DEN === 1'b1) den_cnt++;
            checks++;
            if (bus_b.fila !== 3'(r) || bus_b.DEN !== den_e || bus_b.y !== 2'(y_e) || bus_b.VD !== vd_e) begin
                failures++;
                $display("FAIL frame_b c=%0d r=%0d got=fila%0d den%b y%0d vd%b exp=den%b y%0d vd%b",
                         c, r, bus_b.fila, bus_b.DEN, bus_b.y, bus_b.VD, den_e, y_e, vd_e);
            end
        end
        checks++;
        if (den_cnt != 32) begin
            failures++;
            $display("FAIL den_per_frame got=%0d exp=32", den_cnt);
        end
    endtask

    // EN low for 10 cycles at columna 7: everything holds, then resumes at 8.
    task automatic test_enable_hold();
        bit found;
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus_b.columna === 4'd7) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL hold_align got=timeout exp=columna7");
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus_b.columna !== 4'd7 || obs_b() !== model_b(n_edges)) begin
                failures++;
                $display("FAIL hold_frozen got=%h exp=%h", obs_b(), model_b(n_edges));
            end
            checks++;
            if (obs_d() !== model_d(n_edges)) begin
                failures++;
                $display("FAIL hold_frozen_d got=%h exp=%h", obs_d(), model_d(n_edges));
            end
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_b.columna !== 4'd8 || obs_b() !== model_b(n_edges)) begin
            failures++;
            $display("FAIL hold_resume got=%h exp=%h", obs_b(), model_b(n_edges));
        end
    endtask

    // Reset mid-line takes effect before the next clock edge; restart matches power-up.
    task automatic test_async_reset();
        bit found;
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus_b.columna === 4'd9 && bus_b.fila === 3'd4) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL areset_align got=timeout exp=columna9_fila4");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_b() !== model_b(0) || obs_p() !== model_p(0)) begin
            failures++;
            $display("FAIL areset_immediate got=%h exp=%h", obs_b(), model_b(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            checks++;
            if (obs_b() !== model_b(k)) begin
                failures++;
                $display("FAIL areset_restart k=%0d got=%h exp=%h", k, obs_b(), model_b(k));
            end
        end
    endtask

    // Random EN pattern against the model for all three instances.
    task automatic test_random_enable();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (obs_b() !== model_b(n_edges) || obs_p() !== model_p(n_edges) || obs_d() !== model_d(n_edges)) begin
                failures++;
                $display("FAIL random_en n=%0d got=%h exp=%h", n_edges, obs_b(), model_b(n_edges));
            end
            en = ($urandom_range(0, 3) != 0);
        end
        en = 1'b1;
    endtask

    // Default LTM timing: first active pixel at columna 216, fila 35.
    task automatic test_default_timing();
        bit found;
        rst_n = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40000 && !found; i++) begin
            @(negedge clk);
            if (bus_d.DEN === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL default_den got=timeout exp=den_by_37176");
        end
        checks++;
        if (n_edges != 37176 || bus_d.columna !== 11'd216 || bus_d.fila !== 10'd35) begin
            failures++;
            $display("FAIL default_first_den got=n%0d col%0d fila%0d exp=n37176 col216 fila35",
                     n_edges, bus_d.columna, bus_d.fila);
        end
        checks++;
        if (bus_d.x !== 10'd0 || bus_d.y !== 9'd0 || bus_d.line_start !== 1'b1 || bus_d.HD !== 1'b1) begin
            failures++;
            $display("FAIL default_first_pixel got=x%0d y%0d ls%b hd%b exp=x0 y0 ls1 hd1",
                     bus_d.x, bus_d.y, bus_d.line_start, bus_d.HD);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        test_reset();
        test_frames();
        test_line();
        test_frame();
        test_enable_hold();
        test_async_reset();
        test_random_enable();
        test_default_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
